// File: rtl/uart_burst_pkg.sv
// Shared types and helpers for the UART burst engine.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package uart_burst_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_GAP,
      S_DONE
   } state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   // gap_sel code to a number of gap units; code 3 means four units.
   function automatic int gap_units(input logic [1:0] sel);
      case (sel)
         2'd0:    return 0;
         2'd1:    return 1;
         2'd2:    return 2;
         default: return 4;
      endcase
   endfunction

   // Clock cycles per bit, truncated.
   function automatic int baud_div(input int clk_freq, input int baudrate);
      return clk_freq / baudrate;
   endfunction

endpackage

// File: rtl/uart_burst_engine_timer.sv
// Loadable down-counter with a terminal-count flag (bit and gap timing).
// Latency: load takes effect on the next edge; tc is combinational from the count.
// Backpressure: none; the count holds at zero until reloaded.
// Ports: clk, reset (async, active high), load/load_val, tc (count is zero).
module uart_baud_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/uart_burst_engine.sv
// Sends a burst of burst_len UART frames from a latched payload, with optional
// parity, 1/2 stop bits, a runtime inter-frame gap and an incrementing payload.
// Latency: tx_out falls one cycle after an accepted start. No backpressure: start
// is ignored while busy; abort takes effect only at a frame boundary or in GAP.
// Ports: start/payload/burst_len/gap_sel/inc_mode/abort in; busy, byte_count,
// burst_done, led_byte, tx_out (idle high, registered) out.
module uart_burst_engine
   import uart_burst_pkg::*;
#(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUDRATE  = 57600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int CNT_W     = 8,
   parameter int GAP_UNIT  = 1_000_000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] payload,
   input  logic [CNT_W-1:0]     burst_len,
   input  logic [1:0]           gap_sel,
   input  logic                 inc_mode,
   input  logic                 abort,
   output logic                 busy,
   output logic [CNT_W-1:0]     byte_count,
   output logic                 burst_done,
   output logic                 led_byte,
   output logic                 tx_out
);

   localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUDRATE);
   localparam int BW       = $clog2(STOP_BITS * BAUD_DIV);
   localparam int GW       = $clog2(4 * GAP_UNIT);
   localparam int IW       = $clog2(DATA_BITS);

   localparam logic [BW-1:0] BIT_LD   = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] STOP_LD  = BW'(STOP_BITS * BAUD_DIV - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
   localparam logic          ODD_INV  = (PARITY == PAR_ODD);

   state_t               state, state_n;
   logic [DATA_BITS-1:0] data_q;
   logic [CNT_W-1:0]     len_q;
   logic [1:0]           gap_q;
   logic                 inc_q;
   logic [IW-1:0]        bit_idx, bit_idx_n;
   logic                 bit_load, gap_load, bit_tc, gap_tc;
   logic [BW-1:0]        bit_val;
   logic [GW-1:0]        gap_val;
   logic                 accept, frame_done, tx_n;
   logic [CNT_W-1:0]     cnt_inc;

   assign cnt_inc = byte_count + 1'b1;

   uart_baud_timer #(.W(BW)) u_bit_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (bit_load),
      .load_val (bit_val),
      .tc       (bit_tc)
   );

   uart_baud_timer #(.W(GW)) u_gap_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (gap_load),
      .load_val (gap_val),
      .tc       (gap_tc)
   );

   always_comb begin
      state_n    = state;
      bit_idx_n  = bit_idx;
      bit_load   = 1'b0;
      bit_val    = BIT_LD;
      gap_load   = 1'b0;
      gap_val    = GW'(gap_units(gap_q) * GAP_UNIT - 1);
      accept     = 1'b0;
      frame_done = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept = 1'b1;
               if (burst_len == '0) begin
                  state_n = S_DONE;
               end else begin
                  state_n  = S_START;
                  bit_load = 1'b1;
               end
            end
         end
         S_START: begin
            if (bit_tc) begin
               state_n   = S_DATA;
               bit_idx_n = '0;
               bit_load  = 1'b1;
            end
         end
         S_DATA: begin
            if (bit_tc) begin
               bit_load = 1'b1;
               if (bit_idx != LAST_IDX) begin
                  bit_idx_n = bit_idx + 1'b1;
               end else if (PARITY != PAR_NONE) begin
                  state_n = S_PARITY;
               end else begin
                  state_n = S_STOP;
                  bit_val = STOP_LD;
               end
            end
         end
         S_PARITY: begin
            if (bit_tc) begin
               state_n  = S_STOP;
               bit_load = 1'b1;
               bit_val  = STOP_LD;
            end
         end
         S_STOP: begin
            if (bit_tc) begin
               frame_done = 1'b1;
               // Compare against the count including the frame just finished.
               if (cnt_inc == len_q || abort) begin
                  state_n = S_DONE;
               end else if (gap_q == 2'd0) begin
                  state_n  = S_START;
                  bit_load = 1'b1;
               end else begin
                  state_n  = S_GAP;
                  gap_load = 1'b1;
               end
            end
         end
         S_GAP: begin
            if (abort) begin
               state_n = S_DONE;
            end else if (gap_tc) begin
               state_n  = S_START;
               bit_load = 1'b1;
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // tx_out is registered from the next state so the line moves on the same
   // edge as the state change.
   always_comb begin
      tx_n = 1'b1;
      case (state_n)
         S_START:  tx_n = 1'b0;
         S_DATA:   tx_n = data_q[bit_idx_n];
         S_PARITY: tx_n = (^data_q) ^ ODD_INV;
         default:  tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         bit_idx    <= '0;
         tx_out     <= 1'b1;
         busy       <= 1'b0;
         burst_done <= 1'b0;
      end else begin
         state      <= state_n;
         bit_idx    <= bit_idx_n;
         tx_out     <= tx_n;
         busy       <= (state_n != S_IDLE) && (state_n != S_DONE);
         burst_done <= (state_n == S_DONE);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q     <= '0;
         len_q      <= '0;
         gap_q      <= '0;
         inc_q      <= 1'b0;
         byte_count <= '0;
         led_byte   <= 1'b0;
      end else if (accept) begin
         data_q     <= payload;
         len_q      <= burst_len;
         gap_q      <= gap_sel;
         inc_q      <= inc_mode;
         byte_count <= '0;
      end else if (frame_done) begin
         byte_count <= cnt_inc;
         led_byte   <= ~led_byte;
         if (inc_q)
            data_q <= data_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_burst_engine.sv
// Directed bench for uart_burst_engine: one 8N1 instance and one 8O1 instance
// driven from the same stimulus; line checked every cycle against expected frames.
// Timing: inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_uart_burst_engine;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       inc_mode = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] payload = 8'h00;
   logic [7:0] burst_len = 8'h00;
   logic [1:0] gap_sel = 2'd0;

   logic       busy_n, done_n, led_n, tx_n;
   logic [7:0] bc_n;
   logic       busy_o, done_o, led_o, tx_o;
   logic [7:0] bc_o;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   uart_burst_engine #(
      .CLK_FREQ(1000), .BAUDRATE(100), .DATA_BITS(8), .PARITY(0),
      .STOP_BITS(1), .CNT_W(8), .GAP_UNIT(20)
   ) u_n (
      .clk(clk), .reset(reset), .start(start), .payload(payload),
      .burst_len(burst_len), .gap_sel(gap_sel), .inc_mode(inc_mode),
      .abort(abort), .busy(busy_n), .byte_count(bc_n), .burst_done(done_n),
      .led_byte(led_n), .tx_out(tx_n)
   );

   uart_burst_engine #(
      .CLK_FREQ(1000), .BAUDRATE(100), .DATA_BITS(8), .PARITY(2),
      .STOP_BITS(1), .CNT_W(8), .GAP_UNIT(20)
   ) u_o (
      .clk(clk), .reset(reset), .start(start), .payload(payload),
      .burst_len(burst_len), .gap_sel(gap_sel), .inc_mode(inc_mode),
      .abort(abort), .busy(busy_o), .byte_count(bc_o), .burst_done(done_o),
      .led_byte(led_o), .tx_out(tx_o)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench observing the first cycle after the accepting edge.
   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Checks bit cells lo..hi of a frame, 10 cycles each, LSB (start bit) first.
   task automatic run_frame(input logic sel, input logic [10:0] bits,
                            input int lo, input int hi, input string tag);
      for (int b = lo; b <= hi; b++) begin
         for (int k = 0; k < 10; k++) begin
            chk1($sformatf("%s bit%0d cyc%0d", tag, b, k), sel ? tx_o : tx_n, bits[b]);
            tick();
         end
      end
   endtask

   // 8N1 frame: start 0, data LSB first, stop 1 (bit 10 unused, held high).
   function automatic logic [10:0] f8n1(input logic [7:0] d);
      return {2'b11, d, 1'b0};
   endfunction

   initial begin
      // Reset values
      #12;
      chk1("rst tx_n", tx_n, 1'b1);
      chk1("rst busy_n", busy_n, 1'b0);
      chk8("rst bc_n", bc_n, 8'd0);
      chk1("rst done_n", done_n, 1'b0);
      chk1("rst led_n", led_n, 1'b0);
      chk1("rst tx_o", tx_o, 1'b1);
      chk1("rst busy_o", busy_o, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();

      // 1: 8N1 0xA5, one frame, no gap
      payload = 8'hA5; burst_len = 8'd1; gap_sel = 2'd0; inc_mode = 1'b0;
      pulse_start();
      chk1("t1 busy", busy_n, 1'b1);
      run_frame(1'b0, f8n1(8'hA5), 0, 9, "t1");
      chk1("t1 done", done_n, 1'b1);
      chk1("t1 busy low", busy_n, 1'b0);
      chk8("t1 bc", bc_n, 8'd1);
      chk1("t1 led", led_n, 1'b1);
      tick();
      chk1("t1 done pulse", done_n, 1'b0);
      repeat (30) tick();

      // 2: odd parity, 0x03 then 0x04
      payload = 8'h03; burst_len = 8'd2; inc_mode = 1'b1;
      pulse_start();
      run_frame(1'b1, {1'b1, 1'b1, 8'h03, 1'b0}, 0, 10, "t2f1");
      run_frame(1'b1, {1'b1, 1'b0, 8'h04, 1'b0}, 0, 10, "t2f2");
      chk1("t2 done", done_o, 1'b1);
      chk8("t2 bc", bc_o, 8'd2);
      repeat (20) tick();

      // 3: gap_sel 2 -> 40 idle cycles between frames
      payload = 8'h5A; burst_len = 8'd3; gap_sel = 2'd2; inc_mode = 1'b0;
      pulse_start();
      run_frame(1'b0, f8n1(8'h5A), 0, 9, "t3f1");
      chk1("t3 busy in gap", busy_n, 1'b1);
      run_frame(1'b0, 11'h7FF, 0, 3, "t3gap1");
      run_frame(1'b0, f8n1(8'h5A), 0, 9, "t3f2");
      run_frame(1'b0, 11'h7FF, 0, 3, "t3gap2");
      run_frame(1'b0, f8n1(8'h5A), 0, 9, "t3f3");
      chk1("t3 done", done_n, 1'b1);
      chk8("t3 bc", bc_n, 8'd3);
      repeat (60) tick();

      // 4: abort mid-DATA of frame 2 of 5
      payload = 8'h11; burst_len = 8'd5; gap_sel = 2'd0;
      pulse_start();
      run_frame(1'b0, f8n1(8'h11), 0, 9, "t4f1");
      run_frame(1'b0, f8n1(8'h11), 0, 4, "t4f2a");
      abort = 1'b1;
      run_frame(1'b0, f8n1(8'h11), 5, 9, "t4f2b");
      chk1("t4 done", done_n, 1'b1);
      chk8("t4 bc", bc_n, 8'd2);
      run_frame(1'b0, 11'h7FF, 0, 1, "t4 no start");
      chk8("t4 bc hold", bc_n, 8'd2);
      abort = 1'b0;
      repeat (10) tick();

      // 5: zero-length burst, then start while busy
      burst_len = 8'd0;
      pulse_start();
      chk1("t5 done", done_n, 1'b1);
      chk1("t5 busy", busy_n, 1'b0);
      chk1("t5 tx", tx_n, 1'b1);
      chk1("t5 done_o", done_o, 1'b1);
      chk8("t5 bc", bc_n, 8'd0);
      tick();
      chk1("t5 done pulse", done_n, 1'b0);
      chk1("t5 busy after", busy_n, 1'b0);
      chk1("t5 tx after", tx_n, 1'b1);
      payload = 8'hFF; burst_len = 8'd1;
      pulse_start();
      run_frame(1'b0, f8n1(8'hFF), 0, 2, "t5a");
      payload = 8'h00; burst_len = 8'd3; start = 1'b1;
      run_frame(1'b0, f8n1(8'hFF), 3, 3, "t5b");
      start = 1'b0;
      run_frame(1'b0, f8n1(8'hFF), 4, 9, "t5c");
      chk1("t5 busy-start done", done_n, 1'b1);
      chk8("t5 busy-start bc", bc_n, 8'd1);
      repeat (30) tick();

      // 6: reset mid-DATA, then a clean frame
      payload = 8'h00; burst_len = 8'd1;
      pulse_start();
      run_frame(1'b0, f8n1(8'h00), 0, 3, "t6a");
      chk1("t6 tx low", tx_n, 1'b0);
      reset = 1'b1;
      #1;
      chk1("t6 rst tx", tx_n, 1'b1);
      chk1("t6 rst busy", busy_n, 1'b0);
      chk1("t6 rst tx_o", tx_o, 1'b1);
      chk1("t6 rst busy_o", busy_o, 1'b0);
      chk8("t6 rst bc", bc_n, 8'd0);
      tick();
      reset = 1'b0;
      tick();
      chk1("t6 idle tx", tx_n, 1'b1);
      payload = 8'hC3;
      pulse_start();
      run_frame(1'b0, f8n1(8'hC3), 0, 9, "t6b");
      chk1("t6 done", done_n, 1'b1);
      chk8("t6 bc", bc_n, 8'd1);
      chk1("t6 led", led_n, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_burst_engine.md
Name: uart_burst_engine

Overview:
- Parametrised successor to the Transmitter + FSM pair: one block that sends a burst of `burst_len` UART frames from a latched payload.
- Adds configurable frame format (data bits, parity, stop bits), a runtime inter-byte gap and an incrementing-payload mode.
- Abort is honoured at frame boundaries.
- Sits between system_controller (latched config plus one-second-push start) and the board TX pin. `byte_count` feeds seg_controller.

Parameters:
- CLK_FREQ, 100_000_000: system clock in Hz.
- BAUDRATE, 57600: line rate. BAUD_DIV = CLK_FREQ/BAUDRATE, integer-truncated, must be ≥ 2.
- DATA_BITS, 8: payload bits per frame, legal range 5..9.
- PARITY, 0: 0 none, 1 even, 2 odd.
- STOP_BITS, 1: 1 or 2.
- CNT_W, 8: width of `burst_len` and `byte_count`.
- GAP_UNIT, 1_000_000: clock cycles per gap unit (10 ms at 100 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- payload  in  DATA_BITS  first byte of the burst.
- burst_len  in  CNT_W  frames to send; 0 is legal.
- gap_sel  in  2  idle time between frames, in units of GAP_UNIT: 0, 1, 2 or 4.
- inc_mode  in  1  1: payload increments by 1 (mod 2^DATA_BITS) after each frame.
- abort  in  1  level; stop the burst after the current frame.
- busy  out  1  high from the cycle after an accepted start until burst_done.
- byte_count  out  CNT_W  completed frames in the current or last burst.
- burst_done  out  1  one-cycle pulse at the end of the burst.
- led_byte  out  1  toggles at each completed frame.
- tx_out  out  1  serial line, idle high, registered.

Behaviour:
- Reset values: `tx_out`=1, `busy`=0, `byte_count`=0, `burst_done`=0, `led_byte`=0, state IDLE, all counters 0. Reset mid-frame drives `tx_out` high immediately (asynchronously); no partial frame resumes.
- Start capture:
  - `start` in IDLE latches `payload`, `burst_len`, `gap_sel` and `inc_mode`, and clears `byte_count`.
  - Mid-burst changes to these inputs are ignored.
  - `start` while busy is ignored.
- Zero-length burst: if `burst_len`=0, `burst_done` pulses on the cycle after `start`, `busy` never rises and `tx_out` stays high.
- States: IDLE → START → DATA → PARITY (skipped if PARITY=0) → STOP → GAP (skipped if `gap_sel`=0) → START or DONE → IDLE.
- Bit timing:
  - A baud counter reloads at every state entry, so each bit lasts exactly BAUD_DIV cycles.
  - `tx_out` goes low on the cycle after `start` is accepted (latency 1).
  - DATA sends LSB first; a bit index runs 0..DATA_BITS-1.
  - The parity bit is the XOR of the data bits for even parity, inverted for odd parity.
  - STOP lasts STOP_BITS×BAUD_DIV cycles with `tx_out`=1.
- Frame completion (last STOP cycle):
  - `byte_count` increments and `led_byte` toggles.
  - If `inc_mode`=1, the working payload increments.
  - If `byte_count` now equals the latched length, or `abort` is high, go to DONE.
  - Otherwise go to GAP, then START.
- GAP: `tx_out`=1 for gap_sel_units×GAP_UNIT cycles. `abort` seen during GAP goes to DONE at the end of that cycle.
- DONE: lasts one cycle. `burst_done`=1 and `busy` falls on the same edge; `byte_count` holds until the next accepted start.
- Abort: `abort` during START, DATA, PARITY or STOP never truncates a frame.
- Counter widths: `byte_count` never wraps, since it is bounded by `burst_len` (max 2^CNT_W−1). The gap counter is sized for 4×GAP_UNIT.

Decomposition:
- Package uart_burst_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, GAP, DONE);
  - parity codes PAR_NONE, PAR_EVEN, PAR_ODD;
  - gap decode function (gap_sel → units 0, 1, 2, 4);
  - BAUD_DIV derivation function.
- Sub-module uart_baud_timer: loadable down-counter with a terminal-count flag, instantiated twice (bit timer and gap timer).

Test Plan:
All runs use CLK_FREQ=1000, BAUDRATE=100 (BAUD_DIV=10), GAP_UNIT=20.
1. 8N1, payload 0xA5, `burst_len`=1, `gap_sel`=0:
   - `tx_out` low at cycle+1 for 10 cycles, then data 1,0,1,0,0,1,0,1 at 10 cycles each, then 10 high.
   - `burst_done` pulses at cycle 101, `byte_count`=1, `led_byte`=1.
2. PARITY=2 (odd), payload 0x03, `burst_len`=2, `inc_mode`=1:
   - frame 1 data 0x03 with parity bit 1; frame 2 data 0x04 with parity bit 0;
   - `byte_count`=2.
3. `gap_sel`=2, `burst_len`=3: exactly 40 idle-high cycles between each stop end and the next start bit; total burst 3×100+2×40 cycles.
4. `burst_len`=5, `abort` raised mid-DATA of frame 2:
   - frame 2 completes in full;
   - `burst_done` follows frame 2 stop, `byte_count`=2, no third start bit.
5. `burst_len`=0: `burst_done` pulses at cycle+1, `busy` stays 0, `tx_out` stays 1. A second `start` while busy in another run has no effect.
6. `reset` asserted mid-DATA: `tx_out`=1 and `busy`=0 immediately. After release, a new `start` sends a clean full frame.
